// File: rtl/ui_sensor_pkg.sv
// Shared definitions for the sensor lane alignment logic.
package ui_sensor_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 12;
    localparam int unsigned DATA_W    = NUM_LANES * LANE_W;
    localparam int unsigned SLIP_W    = 4;
    localparam int unsigned POS_W     = 3;

    localparam logic [SLIP_W-1:0] SLIP_CODE = 4'hF;
    localparam logic [SLIP_W-1:0] SLIP_NONE = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_e;

    // Bits needed for a counter that must reach max_val without wrapping.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ui_lane_cmp.sv
// Compares all four lanes of a deserialized word against the training code.
// The match flag and word strobe are registered together so they stay aligned.
module ui_lane_cmp
    import ui_sensor_pkg::*;
#(
    parameter logic [LANE_W-1:0] TRAIN_WORD = 12'h0F3
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_data_valid,
    input  logic [DATA_W-1:0] I_data,
    output logic              O_valid,
    output logic              O_match
);

    logic valid_d, valid_q;
    logic match_d, match_q;

    // All-lane equality against the training code.
    always_comb begin
        valid_d = I_data_valid;
        match_d = 1'b1;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (I_data[k*LANE_W +: LANE_W] != TRAIN_WORD) begin
                match_d = 1'b0;
            end
        end
    end

    // Compare pipeline register.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            match_q <= match_d;
        end
    end

    assign O_valid = valid_q;
    assign O_match = match_q;

endmodule

// File: rtl/ui_bitslip_ctrl.sv
// Word-alignment training controller: settles, checks the training code on all
// lanes, slips the deserializer one position per failed check, and tracks lock.
module ui_bitslip_ctrl
    import ui_sensor_pkg::*;
#(
    parameter logic [LANE_W-1:0] TRAIN_WORD     = 12'h0F3,
    parameter int unsigned       SETTLE_WORDS   = 8,
    parameter int unsigned       MATCH_WORDS    = 16,
    parameter int unsigned       LOSS_WORDS     = 4,
    parameter int unsigned       SLIP_POSITIONS = 6
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_start,
    input  logic              I_train_en,
    input  logic              I_data_valid,
    input  logic [DATA_W-1:0] I_data,
    output logic [SLIP_W-1:0] O_bitslip,
    output logic [POS_W-1:0]  O_slip_pos,
    output logic              O_busy,
    output logic              O_locked,
    output logic              O_fail
);

    localparam int unsigned WORD_CW  = cnt_w(SETTLE_WORDS);
    localparam int unsigned MATCH_CW = cnt_w(MATCH_WORDS);
    localparam int unsigned LOSS_CW  = cnt_w(LOSS_WORDS);
    localparam int unsigned TRY_CW   = cnt_w(SLIP_POSITIONS);

    state_e              state_d, state_q;
    logic [WORD_CW-1:0]  word_cnt_d, word_cnt_q;
    logic [MATCH_CW-1:0] match_cnt_d, match_cnt_q;
    logic [LOSS_CW-1:0]  loss_cnt_d, loss_cnt_q;
    logic [TRY_CW-1:0]   try_cnt_d, try_cnt_q;
    logic [POS_W-1:0]    slip_pos_d, slip_pos_q;
    logic [SLIP_W-1:0]   bitslip_d, bitslip_q;
    logic                busy_d, busy_q;
    logic                locked_d, locked_q;
    logic                fail_d, fail_q;
    logic                train_en_d, train_en_q;

    logic                cmp_valid;
    logic                cmp_match;
    logic [WORD_CW-1:0]  word_inc_c;
    logic [MATCH_CW-1:0] match_inc_c;
    logic [LOSS_CW-1:0]  loss_inc_c;

    ui_lane_cmp #(
        .TRAIN_WORD (TRAIN_WORD)
    ) u_lane_cmp (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_data_valid (I_data_valid),
        .I_data       (I_data),
        .O_valid      (cmp_valid),
        .O_match      (cmp_match)
    );

    assign word_inc_c  = word_cnt_q + WORD_CW'(1);
    assign match_inc_c = match_cnt_q + MATCH_CW'(1);
    assign loss_inc_c  = loss_cnt_q + LOSS_CW'(1);

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        match_cnt_d = match_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        try_cnt_d   = try_cnt_q;
        slip_pos_d  = slip_pos_q;
        train_en_d  = I_train_en;

        if (I_start) begin
            // Restart wins over everything; alignment position is kept.
            state_d     = ST_SETTLE;
            word_cnt_d  = '0;
            match_cnt_d = '0;
            loss_cnt_d  = '0;
            try_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_SETTLE: begin
                    if (cmp_valid) begin
                        if (word_inc_c == WORD_CW'(SETTLE_WORDS)) begin
                            state_d     = ST_CHECK;
                            word_cnt_d  = '0;
                            match_cnt_d = '0;
                        end else begin
                            word_cnt_d = word_inc_c;
                        end
                    end
                end
                ST_CHECK: begin
                    if (cmp_valid) begin
                        if (cmp_match) begin
                            if (match_inc_c == MATCH_CW'(MATCH_WORDS)) begin
                                state_d     = ST_LOCKED;
                                match_cnt_d = '0;
                                loss_cnt_d  = '0;
                            end else begin
                                match_cnt_d = match_inc_c;
                            end
                        end else begin
                            match_cnt_d = '0;
                            if (try_cnt_q < TRY_CW'(SLIP_POSITIONS - 1)) begin
                                // Position and try count advance with the pulse.
                                state_d   = ST_SLIP;
                                try_cnt_d = try_cnt_q + TRY_CW'(1);
                                if (slip_pos_q == POS_W'(SLIP_POSITIONS - 1)) begin
                                    slip_pos_d = '0;
                                end else begin
                                    slip_pos_d = slip_pos_q + POS_W'(1);
                                end
                            end else begin
                                state_d = ST_FAIL;
                            end
                        end
                    end
                end
                ST_SLIP: begin
                    state_d    = ST_SETTLE;
                    word_cnt_d = '0;
                end
                ST_LOCKED: begin
                    if (!train_en_q) begin
                        loss_cnt_d = '0;
                    end else if (cmp_valid) begin
                        if (cmp_match) begin
                            loss_cnt_d = '0;
                        end else if (loss_inc_c == LOSS_CW'(LOSS_WORDS)) begin
                            state_d     = ST_SETTLE;
                            loss_cnt_d  = '0;
                            word_cnt_d  = '0;
                            match_cnt_d = '0;
                            try_cnt_d   = '0;
                        end else begin
                            loss_cnt_d = loss_inc_c;
                        end
                    end
                end
                ST_FAIL: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        bitslip_d = (state_d == ST_SLIP) ? SLIP_CODE : SLIP_NONE;
        busy_d    = (state_d == ST_SETTLE) || (state_d == ST_CHECK) || (state_d == ST_SLIP);
        locked_d  = (state_d == ST_LOCKED);
        fail_d    = (state_d == ST_FAIL);
    end

    // State, counters and output registers.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            match_cnt_q <= '0;
            loss_cnt_q  <= '0;
            try_cnt_q   <= '0;
            slip_pos_q  <= '0;
            bitslip_q   <= SLIP_NONE;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            train_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            match_cnt_q <= match_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            try_cnt_q   <= try_cnt_d;
            slip_pos_q  <= slip_pos_d;
            bitslip_q   <= bitslip_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            train_en_q  <= train_en_d;
        end
    end

    assign O_bitslip  = bitslip_q;
    assign O_slip_pos = slip_pos_q;
    assign O_busy     = busy_q;
    assign O_locked   = locked_q;
    assign O_fail     = fail_q;

endmodule

// File: tb/tb_ui_bitslip_ctrl.sv
// Bench for ui_bitslip_ctrl: a deserializer model follows the slip pulses, and
// expected slip/lock/fail events are queued ahead of stimulus and popped by a monitor.
module tb_ui_bitslip_ctrl;

    localparam logic [11:0] TRAIN = 12'h0F3;
    localparam logic [11:0] BAD   = 12'h1E6;

    localparam int EV_SLIP   = 0;
    localparam int EV_LOCK   = 1;
    localparam int EV_UNLOCK = 2;
    localparam int EV_FAIL   = 3;
    localparam int EV_UNFAIL = 4;

    typedef struct {
        int kind;
        int pos;
    } ev_t;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_start = 1'b0;
    logic        I_train_en = 1'b1;
    logic        I_data_valid = 1'b0;
    logic [47:0] I_data = '0;
    logic [3:0]  O_bitslip;
    logic [2:0]  O_slip_pos;
    logic        O_busy;
    logic        O_locked;
    logic        O_fail;

    int   ntests = 0;
    int   nfail  = 0;
    ev_t  sb[$];
    int   tb_pos = 0;
    int   good_pos = 0;

    logic [3:0] prev_bs = 4'h0;
    logic       prev_locked = 1'b0;
    logic       prev_fail = 1'b0;

    ui_bitslip_ctrl dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_start      (I_start),
        .I_train_en   (I_train_en),
        .I_data_valid (I_data_valid),
        .I_data       (I_data),
        .O_bitslip    (O_bitslip),
        .O_slip_pos   (O_slip_pos),
        .O_busy       (O_busy),
        .O_locked     (O_locked),
        .O_fail       (O_fail)
    );

    always #5 I_clk = ~I_clk;

    // Deserializer model: advances one position per slip pulse, wraps 5 -> 0.
    always @(posedge I_clk or posedge I_rst) begin
        if (I_rst) tb_pos <= 0;
        else if (O_bitslip == 4'hF) tb_pos <= (tb_pos == 5) ? 0 : tb_pos + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input int pos);
        ev_t e;
        e.kind = kind;
        e.pos  = pos;
        sb.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int pos);
        ev_t e;
        ntests++;
        if (sb.size() == 0) begin
            nfail++;
            $display("FAIL sb_unexpected: got kind=%0d pos=%0d, expected no event (t=%0t)", kind, pos, $time);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.pos != pos) begin
                nfail++;
                $display("FAIL sb_event: got kind=%0d pos=%0d expected kind=%0d pos=%0d (t=%0t)",
                         kind, pos, e.kind, e.pos, $time);
            end
        end
    endtask

    // Monitor: turns output edges into events and checks them against the queue.
    always @(negedge I_clk) begin
        if (!I_rst) begin
            if (prev_bs != 4'h0) begin
                chk("slip_one_cycle", int'(O_bitslip), 0);
                got_ev(EV_SLIP, int'(O_slip_pos));
            end
            if (O_bitslip != 4'h0 && prev_bs == 4'h0) chk("slip_code", int'(O_bitslip), 15);
            if (O_locked && !prev_locked) got_ev(EV_LOCK, int'(O_slip_pos));
            if (!O_locked && prev_locked) got_ev(EV_UNLOCK, int'(O_slip_pos));
            if (O_fail && !prev_fail) got_ev(EV_FAIL, int'(O_slip_pos));
            if (!O_fail && prev_fail) got_ev(EV_UNFAIL, int'(O_slip_pos));
        end
        prev_bs     = O_bitslip;
        prev_locked = O_locked;
        prev_fail   = O_fail;
    end

    function automatic logic [47:0] mk_word(input logic [3:0] mask);
        logic [47:0] w;
        for (int k = 0; k < 4; k++)
            w[k*12 +: 12] = (mask[k] || (tb_pos != good_pos)) ? BAD : TRAIN;
        return w;
    endfunction

    // One clock of stimulus: drive on the falling edge, return after the rising edge.
    task automatic cyc(input logic v, input logic st, input logic [3:0] mask);
        @(negedge I_clk);
        I_data_valid = v;
        I_start      = st;
        I_data       = mk_word(mask);
        @(posedge I_clk);
    endtask

    task automatic cyc_rnd();
        @(negedge I_clk);
        I_data_valid = 1'b1;
        I_start      = 1'b0;
        I_data       = {16'($urandom), $urandom};
        @(posedge I_clk);
    endtask

    task automatic do_reset();
        #1 I_rst = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 4'h0);
        #1 I_rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bitslip"}, int'(O_bitslip), 0);
        chk({tag, "_pos"}, int'(O_slip_pos), 0);
        chk({tag, "_busy"}, int'(O_busy), 0);
        chk({tag, "_locked"}, int'(O_locked), 0);
        chk({tag, "_fail"}, int'(O_fail), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        repeat (3) @(posedge I_clk);
        #1 chk_reset_vals("rst");
        I_rst = 1'b0;
        repeat (3) cyc(1'b1, 1'b0, 4'h0);
        chk("idle_busy", int'(O_busy), 0);

        // Aligned from the start: lock at position 0 with no slips.
        good_pos = 0;
        expect_ev(EV_LOCK, 0);
        cyc(1'b0, 1'b1, 4'h0);
        repeat (24) cyc(1'b1, 1'b0, 4'h0);
        #1 chk("no_early_lock", int'(O_locked), 0);
        repeat (6) cyc(1'b1, 1'b0, 4'h0);
        #1 chk("t1_locked", int'(O_locked), 1);
        chk("t1_pos", int'(O_slip_pos), 0);
        chk("t1_busy", int'(O_busy), 0);

        // Correct alignment at position 3: three slips, then lock.
        good_pos = 3;
        expect_ev(EV_UNLOCK, 0);
        expect_ev(EV_SLIP, 1);
        expect_ev(EV_SLIP, 2);
        expect_ev(EV_SLIP, 3);
        expect_ev(EV_LOCK, 3);
        cyc(1'b0, 1'b1, 4'h0);
        repeat (80) cyc(1'b1, 1'b0, 4'h0);
        #1 chk("t2_locked", int'(O_locked), 1);
        chk("t2_pos", int'(O_slip_pos), 3);

        // No position matches: five slips then FAIL; start clears it.
        do_reset();
        #1 chk("t3_pos_rst", int'(O_slip_pos), 0);
        good_pos = -1;
        expect_ev(EV_SLIP, 1);
        expect_ev(EV_SLIP, 2);
        expect_ev(EV_SLIP, 3);
        expect_ev(EV_SLIP, 4);
        expect_ev(EV_SLIP, 5);
        expect_ev(EV_FAIL, 5);
        cyc(1'b0, 1'b1, 4'h0);
        repeat (80) cyc(1'b1, 1'b0, 4'h0);
        #1 chk("t3_fail", int'(O_fail), 1);
        chk("t3_busy", int'(O_busy), 0);
        chk("t3_pos", int'(O_slip_pos), 5);
        chk("t3_bitslip", int'(O_bitslip), 0);
        good_pos = 5;
        expect_ev(EV_UNFAIL, 5);
        expect_ev(EV_LOCK, 5);
        cyc(1'b0, 1'b1, 4'h0);
        #1 chk("t3_restart_busy", int'(O_busy), 1);
        chk("t3_restart_fail", int'(O_fail), 0);
        repeat (40) cyc(1'b1, 1'b0, 4'h0);
        #1 chk("t3_relock", int'(O_locked), 1);

        // Loss of lock: three single-lane mismatches are tolerated, four are not.
        cyc(1'b1, 1'b0, 4'h8);
        cyc(1'b1, 1'b0, 4'h4);
        cyc(1'b1, 1'b0, 4'h2);
        repeat (10) cyc(1'b1, 1'b0, 4'h0);
        #1 chk("t4_held", int'(O_locked), 1);
        expect_ev(EV_UNLOCK, 5);
        expect_ev(EV_LOCK, 5);
        cyc(1'b1, 1'b0, 4'h1);
        cyc(1'b1, 1'b0, 4'h2);
        cyc(1'b1, 1'b0, 4'h4);
        cyc(1'b1, 1'b0, 4'h8);
        repeat (40) cyc(1'b1, 1'b0, 4'h0);
        #1 chk("t4_relock", int'(O_locked), 1);

        // Training disabled: random data must not disturb lock.
        I_train_en = 1'b0;
        repeat (30) cyc_rnd();
        repeat (3) cyc(1'b1, 1'b0, 4'h0);
        I_train_en = 1'b1;
        repeat (5) cyc(1'b1, 1'b0, 4'h0);
        #1 chk("t5_held", int'(O_locked), 1);

        // Start coinciding with a mismatch in CHECK restarts without slipping.
        expect_ev(EV_UNLOCK, 5);
        expect_ev(EV_LOCK, 5);
        cyc(1'b0, 1'b1, 4'h0);
        repeat (8) cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'hF);
        cyc(1'b1, 1'b1, 4'h0);
        #1 chk("t5_no_slip", int'(O_bitslip), 0);
        chk("t5_busy", int'(O_busy), 1);
        repeat (40) cyc(1'b1, 1'b0, 4'h0);
        #1 chk("t5_relock", int'(O_locked), 1);

        // Reset during the slip pulse.
        good_pos = -1;
        expect_ev(EV_UNLOCK, 5);
        cyc(1'b0, 1'b1, 4'h0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1'b1, 1'b0, 4'h0);
            #1 if (O_bitslip == 4'hF) found = 1'b1;
        end
        chk("t6_slip_seen", int'(found), 1);
        #1 I_rst = 1'b1;
        #1 chk_reset_vals("t6_async");
        repeat (2) cyc(1'b1, 1'b0, 4'h0);
        #1 I_rst = 1'b0;
        repeat (20) cyc(1'b1, 1'b0, 4'h0);
        #1 chk_reset_vals("t6_idle");

        repeat (5) cyc(1'b0, 1'b0, 4'h0);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/ui_bitslip_ctrl.md
UI_BITSLIP_CTRL -- requirements
Module: ui_bitslip_ctrl

Interface
REQ-001 Parameter TRAIN_WORD, default 12'h0F3, 12-bit sensor training code expected on every lane during training.
REQ-002 Parameter SETTLE_WORDS, default 8, valid words discarded after start or slip before checking.
REQ-003 Parameter MATCH_WORDS, default 16, consecutive all-lane matches required to declare lock.
REQ-004 Parameter LOSS_WORDS, default 4, consecutive mismatches in LOCKED (training enabled) that drop lock.
REQ-005 Parameter SLIP_POSITIONS, default 6, word-alignment positions available in the deserializer.
REQ-006 I_clk  in  1  deserializer parallel-side clock (data_clk domain); all logic on rising edge.
REQ-007 I_rst  in  1  asynchronous, active-high reset.
REQ-008 I_start  in  1  single-cycle request to (re)start alignment training.
REQ-009 I_train_en  in  1  high while the sensor transmits the training code.
REQ-010 I_data_valid  in  1  deserializer word strobe.
REQ-011 I_data  in  48  deserialized word; lane k = I_data[12k+11:12k], k=0..3.
REQ-012 O_bitslip  out  4  slip command to deserializer; 4'hF = advance one position, else 4'h0.
REQ-013 O_slip_pos  out  3  current alignment position, 0..SLIP_POSITIONS-1.
REQ-014 O_busy  out  1  high in SETTLE, CHECK, SLIP.
REQ-015 O_locked  out  1  high in LOCKED.
REQ-016 O_fail  out  1  high in FAIL.

Function
REQ-017 States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL; one-hot or binary, registered outputs.
REQ-018 I_start in any state: next state SETTLE, word counter, match counter and try counter cleared; O_slip_pos unchanged; I_start has priority over every other transition in the same cycle.
REQ-019 SETTLE: count I_data_valid words; on the SETTLE_WORDS-th valid word go to CHECK.
REQ-020 CHECK: valid word with all four lanes == TRAIN_WORD increments match counter; reaching MATCH_WORDS goes to LOCKED next cycle.
REQ-021 CHECK: valid word with any lane mismatch clears match counter and goes to SLIP if tries < SLIP_POSITIONS-1, else to FAIL.
REQ-022 SLIP: lasts exactly one cycle; O_bitslip = 4'hF that cycle only; O_slip_pos increments, wrapping SLIP_POSITIONS-1 -> 0; try counter increments; next state SETTLE.
REQ-023 O_bitslip is 4'h0 in every state other than SLIP; no two slip pulses closer than SETTLE_WORDS valid words + 1 cycle.
REQ-024 LOCKED with I_train_en=1: mismatch word increments loss counter, match word clears it; reaching LOSS_WORDS goes to SETTLE with try counter cleared (retrain).
REQ-025 LOCKED with I_train_en=0: loss counter held at 0, data ignored, lock held.
REQ-026 FAIL: held until I_start; O_slip_pos held.
REQ-027 IDLE: entered only from reset; I_data_valid ignored in IDLE and FAIL.
REQ-028 Counters sized to hold their parameter value; no wrap inside SETTLE/CHECK/LOCKED.

Reset
REQ-029 I_rst asserted: state IDLE, all counters 0, O_bitslip 4'h0, O_slip_pos 0, O_busy 0, O_locked 0, O_fail 0, asynchronously.
REQ-030 Reset mid-SLIP clears O_bitslip immediately; deserializer slip counter is reset by the same system reset so O_slip_pos stays consistent.

Structure
REQ-031 State encoding, lane count (4), lane width (12), 4'hF slip code in shared package ui_sensor_pkg.
REQ-032 One sub-module natural: ui_lane_cmp (4x12-bit compare to TRAIN_WORD, registered all-match flag); FSM and counters in top.

Verification
REQ-033 Data always aligned, TRAIN_WORD on all lanes, start pulse -> no slip, O_locked after 8+16 valid words, O_slip_pos=0.
REQ-034 Correct alignment at position 3 -> exactly three one-cycle 4'hF pulses, O_locked=1, O_slip_pos=3.
REQ-035 No position ever matches -> five slips then O_fail=1, O_busy=0, O_slip_pos=5; I_start clears O_fail and re-enters SETTLE.
REQ-036 Locked, train_en=1, 4 consecutive mismatches -> O_locked drops, retrain; 3 mismatches then match -> lock held.
REQ-037 Locked, train_en=0, random data -> lock held; I_start and mismatch same cycle in CHECK -> SETTLE, no slip.
REQ-038 I_rst asserted during SLIP cycle -> O_bitslip 0 same cycle, all outputs reset values.
